// File: rtl/demux_logic_pkg.sv
// Shared definitions for the demux-built logic unit: operation encodings and widths.
package demux_logic_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_NOT_A  = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XOR    = 3'd5,
        OP_XNOR   = 3'd6,
        OP_PASS_A = 3'd7
    } op_e;

endpackage

// File: rtl/demux_bit_alu.sv
// One-bit, eight-operation logic evaluator whose gates are all two_one_demux cells.
module demux_bit_alu
    import demux_logic_pkg::*;
(
    input  logic            a_i,
    input  logic            b_i,
    input  logic [OP_W-1:0] op_i,
    output logic            y_o
);

    logic n_a, n_b, and_ab, and_nn, or_ab, and_anb, and_nab;
    logic n_x1, n_x2, and_nx, xor_ab, nand_ab, nor_ab, xnor_ab;
    logic [13:0] cell_unused;

    // NOT x = demux(1, x).y0 ; AND(p, q) = demux(p, q).y1
    two_one_demux u_not_a   (.d_i(1'b1),    .sel_i(a_i),     .y0_o(n_a),            .y1_o(cell_unused[0]));
    two_one_demux u_not_b   (.d_i(1'b1),    .sel_i(b_i),     .y0_o(n_b),            .y1_o(cell_unused[1]));
    two_one_demux u_and_ab  (.d_i(a_i),     .sel_i(b_i),     .y0_o(cell_unused[2]), .y1_o(and_ab));
    two_one_demux u_and_nn  (.d_i(n_a),     .sel_i(n_b),     .y0_o(cell_unused[3]), .y1_o(and_nn));
    two_one_demux u_or_ab   (.d_i(1'b1),    .sel_i(and_nn),  .y0_o(or_ab),          .y1_o(cell_unused[4]));
    two_one_demux u_and_anb (.d_i(a_i),     .sel_i(n_b),     .y0_o(cell_unused[5]), .y1_o(and_anb));
    two_one_demux u_and_nab (.d_i(n_a),     .sel_i(b_i),     .y0_o(cell_unused[6]), .y1_o(and_nab));
    two_one_demux u_not_x1  (.d_i(1'b1),    .sel_i(and_anb), .y0_o(n_x1),           .y1_o(cell_unused[7]));
    two_one_demux u_not_x2  (.d_i(1'b1),    .sel_i(and_nab), .y0_o(n_x2),           .y1_o(cell_unused[8]));
    two_one_demux u_and_nx  (.d_i(n_x1),    .sel_i(n_x2),    .y0_o(cell_unused[9]), .y1_o(and_nx));
    two_one_demux u_xor     (.d_i(1'b1),    .sel_i(and_nx),  .y0_o(xor_ab),         .y1_o(cell_unused[10]));
    two_one_demux u_nand    (.d_i(1'b1),    .sel_i(and_ab),  .y0_o(nand_ab),        .y1_o(cell_unused[11]));
    two_one_demux u_nor     (.d_i(1'b1),    .sel_i(or_ab),   .y0_o(nor_ab),         .y1_o(cell_unused[12]));
    two_one_demux u_xnor    (.d_i(1'b1),    .sel_i(xor_ab),  .y0_o(xnor_ab),        .y1_o(cell_unused[13]));

    always_comb begin
        // NOTE: default assignment first so every path drives y_o and no latch is inferred.
        y_o = 1'b0;
        case (op_e'(op_i))
            OP_AND:    y_o = and_ab;
            OP_OR:     y_o = or_ab;
            OP_NOT_A:  y_o = n_a;
            OP_NAND:   y_o = nand_ab;
            OP_NOR:    y_o = nor_ab;
            OP_XOR:    y_o = xor_ab;
            OP_XNOR:   y_o = xnor_ab;
            OP_PASS_A: y_o = a_i;
            default:   y_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/two_one_demux.sv
// 1-to-2 demultiplexer cell: routes d to y0 when sel=0, to y1 when sel=1.
module two_one_demux (
    input  logic d_i,
    input  logic sel_i,
    output logic y0_o,
    output logic y1_o
);

    assign y0_o = d_i & ~sel_i;
    assign y1_o = d_i &  sel_i;

endmodule

// File: rtl/demux_logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit (operand regs -> result regs) with a
// saturating count of completed output handshakes.
module demux_logic_unit_pipe
    import demux_logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d, alu_y;
    logic [OP_W-1:0]  op_q, op_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_load, s2_load;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        demux_bit_alu u_bit (
            .a_i  (a_q[i]),
            .b_i  (b_q[i]),
            .op_i (op_q),
            .y_o  (alu_y[i])
        );
    end

    // S1 can take a beat when it is empty or moving its beat forward this cycle.
    assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_load;
    assign s1_load  = in_valid & in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        s2_valid_d = s2_valid_q;
        y_d        = y_q;
        zero_d     = zero_q;
        cnt_d      = cnt_q;

        if (s1_load) begin
            s1_valid_d = 1'b1;
            a_d        = in_a;
            b_d        = in_b;
            op_d       = in_op;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            s2_valid_d = 1'b1;
            y_d        = alu_y;
            zero_d     = ~|alu_y;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid && out_ready && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, so out_y/out_zero read 0 out of reset.
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            zero_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            zero_q     <= zero_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_y     = y_q;
    assign out_zero  = zero_q;
    assign op_count  = cnt_q;

endmodule
